simd_result_writer: RTL

Output-side writer for the bilinear SIMD datapath. It consumes the lane vector and one-cycle valid pulse from the SIMD interpolation core, buffers results in a small FIFO, and writes them as packed words into destination image memory. Address generation follows a row-major raster with a configurable stride. Destination memory may apply backpressure through a ready handshake.

---
 rtl/simd_result_writer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/simd_result_writer.sv
// simd_result_writer
//
// Output-side writer for the bilinear SIMD datapath. Result vectors from the
// SIMD interpolation core are buffered in a small FIFO and written as packed
// words into destination image memory. Addresses follow a row-major raster
// with a configurable row stride. Memory backpressure is honoured through a
// ready handshake.
//
// Optional feature macro: SIMD_WR_CHECKSUM_EN
//   defined   -> o_checksum is the mod-2^16 sum of every byte written this frame
//   undefined -> no accumulator; o_checksum is tied to 0
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   i_frame_start       pulse; latches the frame config and starts a frame (IDLE only)
//   i_dst_base          word address of destination pixel (0,0)
//   i_dst_words         words per output row (>= 1)
//   i_dst_rows          output rows (>= 1)
//   i_dst_stride        word distance between row starts
//   i_pixel_vec         result vector, lane 0 in bits [7:0]
//   i_valid             pulse; i_pixel_vec is valid
//   o_mem_we            write request
//   o_mem_addr          write word address
//   o_mem_wdata         write data (FIFO head)
//   i_mem_ready         memory accepts the write when o_mem_we && i_mem_ready
//   o_busy              high while a frame is running
//   o_done              one-cycle pulse after the last word is accepted
//   o_overflow          sticky; a valid vector was dropped on a full FIFO
//   o_checksum          byte checksum of accepted writes (see macro above)

module simd_result_writer #(
  parameter int LANES      = 4,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_frame_start,
  input  logic [ADDR_W-1:0]    i_dst_base,
  input  logic [15:0]          i_dst_words,
  input  logic [15:0]          i_dst_rows,
  input  logic [ADDR_W-1:0]    i_dst_stride,
  input  logic [8*LANES-1:0]   i_pixel_vec,
  input  logic                 i_valid,
  output logic                 o_mem_we,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [8*LANES-1:0]   o_mem_wdata,
  input  logic                 i_mem_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic [15:0]          o_checksum
);

  localparam int DW = 8 * LANES;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  // Latched frame configuration
  logic [ADDR_W-1:0] stride_q;
  logic [15:0]       words_q;
  logic [15:0]       rows_q;

  // Raster position
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] row_base;
  logic [15:0]       col;
  logic [15:0]       row;

  // Result FIFO
  logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;

  logic fifo_full;
  logic fifo_empty;
  logic start;
  logic accept;
  logic push;
  logic drop;
  logic flush;
  logic last_col;
  logic last_word;
  logic overflow_q;

  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  assign start  = (state == IDLE) && i_frame_start;
  assign accept = o_mem_we && i_mem_ready;

  // A full FIFO can still take a vector when its head leaves in the same cycle.
  assign push = (state == RUN) && i_valid && (!fifo_full || accept);
  assign drop = (state == RUN) && i_valid && !push;

  // Leftover entries are discarded both when leaving DONE and on a new frame.
  assign flush = start || (state == DONE);

  assign last_col  = (col == (words_q - 16'd1));
  assign last_word = accept && last_col && (row == (rows_q - 16'd1));

  assign o_mem_we    = (state == RUN) && !fifo_empty;
  assign o_mem_addr  = addr;
  assign o_mem_wdata = o_mem_we ? fifo_mem[rd_ptr] : '0;
  assign o_busy      = (state == RUN);
  assign o_done      = (state == DONE);
  assign o_overflow  = overflow_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_frame_start) state_next = RUN;
      RUN:     if (last_word)     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame configuration, raster address generation and the overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q   <= '0;
      words_q    <= '0;
      rows_q     <= '0;
      addr       <= '0;
      row_base   <= '0;
      col        <= '0;
      row        <= '0;
      overflow_q <= 1'b0;
    end else if (start) begin
      stride_q   <= i_dst_stride;
      words_q    <= i_dst_words;
      rows_q     <= i_dst_rows;
      addr       <= i_dst_base;
      row_base   <= i_dst_base;
      col        <= '0;
      row        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (accept) begin
        if (last_col) begin
          col      <= '0;
          row      <= row + 16'd1;
          row_base <= row_base + stride_q;
          addr     <= row_base + stride_q;
        end else begin
          col  <= col + 16'd1;
          addr <= addr + ADDR_W'(1);
        end
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (accept) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, accept})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only observed through valid entries
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_pixel_vec;
    end
  end

`ifdef SIMD_WR_CHECKSUM_EN
  logic [15:0] byte_sum;
  logic [15:0] checksum_q;

  // Sum of the lane bytes of the word currently on the bus
  always_comb begin
    byte_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      byte_sum = byte_sum + 16'(o_mem_wdata[8*i +: 8]);
    end
  end

  // Accumulate accepted words; the value holds after DONE until the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (start) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + byte_sum;
    end
  end

  assign o_checksum = checksum_q;
`else
  assign o_checksum = '0;
`endif

endmodule
